hid_report_scheduler: RTL

Sequences keyboard make/break events into complete 8-byte HID boot-keyboard reports for the CH9328 UART bridge.
- Buffers incoming key events in a small FIFO.
- Maintains the pressed-key state: modifier byte plus six key slots.
- Drives one full report frame per event over a valid/ready byte handshake into the uart_tx instance.
- Enforces an inter-report gap between frames.
Sits between the scan/decode logic and uart_tx. It replaces single-shot report sending with multi-key (6KRO) tracking.

---
 rtl/hid_pkg.sv | 26 ++
 rtl/hid_report_scheduler_fifo.sv | 65 ++++++
 rtl/hid_report_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hid_pkg.sv
// hid_pkg
// Shared definitions for the HID report scheduler: scheduler state encoding,
// HID usage constants for the boot-keyboard report, and a small helper that
// classifies a usage as a modifier key.
package hid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    localparam logic [7:0] HID_MOD_FIRST  = 8'hE0;
    localparam logic [7:0] HID_MOD_LAST   = 8'hE7;
    localparam logic [7:0] HID_USAGE_NONE = 8'h00;

    localparam int REPORT_BYTES = 8;
    localparam int KEY_SLOTS    = 6;

    // Usages E0..E7 live in the modifier byte rather than in a key slot.
    function automatic logic is_modifier(input logic [7:0] usage);
        return (usage >= HID_MOD_FIRST) && (usage <= HID_MOD_LAST);
    endfunction

endpackage

// File: rtl/hid_report_scheduler_fifo.sv
// hid_event_fifo
// Synchronous FIFO holding raw key events until the scheduler is ready to
// turn them into reports. A push is accepted when there is room or when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   push, data     write strobe and write data
//   pop            remove the head entry
//   head           current head entry (combinational)
//   empty, full    occupancy flags
//   count          number of stored entries
module hid_event_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/hid_report_scheduler.sv
// hid_report_scheduler
// Turns queued keyboard make/break events into complete 8-byte HID
// boot-keyboard reports for the CH9328 bridge. Tracks the modifier byte and
// six key slots (6KRO), sends one report per mapped event over a valid/ready
// byte handshake, and holds an idle gap after each report.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   on_event          one-cycle strobe qualifying key_event
//   key_event         [7]=make/break, [6:0]=key index
//   map_addr          key index at the FIFO head, to the external usage ROM
//   map_data          HID usage returned by the ROM (0x00 = unmapped)
//   tx_data/tx_valid  report byte stream to uart_tx
//   tx_ready          uart_tx byte acceptance
//   busy              scheduler not idle
//   fifo_overflow     sticky: an event was dropped, FIFO full
//   rollover_err      sticky: a make was dropped, all slots occupied
module hid_report_scheduler
    import hid_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       on_event,
    input  logic [7:0] key_event,
    output logic [6:0] map_addr,
    input  logic [7:0] map_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       fifo_overflow,
    output logic       rollover_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_t     state;
    logic [2:0]       byte_idx;
    logic [GAP_W-1:0] gap_count;
    logic [7:0]       modifier;
    logic [7:0]       slots [KEY_SLOTS];

    logic [7:0]       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;

    logic [7:0]       next_modifier;
    logic [7:0]       next_slots [KEY_SLOTS];
    logic             next_rollover;
    logic [2:0]       next_idx;
    logic [7:0]       next_byte;

    assign fifo_pop  = (state == ST_LOAD);
    assign fifo_push = on_event && ((fifo_count < CNT_W'(FIFO_DEPTH)) || fifo_pop);
    assign map_addr  = fifo_head[6:0];

    hid_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .data (key_event),
        .pop  (fifo_pop),
        .head (fifo_head),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

    // Candidate table after applying the head event; only committed in LOAD.
    always_comb begin
        logic       held;
        logic       free_found;
        logic [2:0] free_idx;

        next_modifier = modifier;
        next_slots    = slots;
        next_rollover = 1'b0;
        held          = 1'b0;
        free_found    = 1'b0;
        free_idx      = 3'd0;

        if (is_modifier(map_data)) begin
            next_modifier[map_data[2:0]] = fifo_head[7];
        end else if (fifo_head[7]) begin
            for (int i = 0; i < KEY_SLOTS; i++) begin
                if (slots[i] == map_data) begin
                    held = 1'b1;
                end
            end
            // Descending scan leaves the lowest free slot selected.
            for (int i = KEY_SLOTS - 1; i >= 0; i--) begin
                if (slots[i] == HID_USAGE_NONE) begin
                    free_found = 1'b1;
                    free_idx   = 3'(i);
                end
            end
            if (!held) begin
                if (free_found) begin
                    next_slots[free_idx] = map_data;
                end else begin
                    next_rollover = 1'b1;
                end
            end
        end else begin
            // Breaks clear matching slots in place; no compaction.
            for (int i = 0; i < KEY_SLOTS; i++) begin
                if (slots[i] == map_data) begin
                    next_slots[i] = HID_USAGE_NONE;
                end
            end
        end
    end

    // Byte that follows the current one in the report.
    always_comb begin
        next_idx = byte_idx + 3'd1;
        case (next_idx)
            3'd0:    next_byte = modifier;
            3'd1:    next_byte = HID_USAGE_NONE;
            default: next_byte = slots[next_idx - 3'd2];
        endcase
    end

    // Scheduler FSM; tx outputs and busy are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            byte_idx      <= 3'd0;
            gap_count     <= '0;
            modifier      <= HID_USAGE_NONE;
            for (int i = 0; i < KEY_SLOTS; i++) begin
                slots[i] <= HID_USAGE_NONE;
            end
            tx_data       <= HID_USAGE_NONE;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            fifo_overflow <= 1'b0;
            rollover_err  <= 1'b0;
        end else begin
            if (on_event && fifo_full && !fifo_pop) begin
                fifo_overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (map_data == HID_USAGE_NONE) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        modifier <= next_modifier;
                        slots    <= next_slots;
                        if (next_rollover) begin
                            rollover_err <= 1'b1;
                        end
                        byte_idx <= 3'd0;
                        tx_data  <= next_modifier;
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == 3'(REPORT_BYTES - 1)) begin
                            tx_valid  <= 1'b0;
                            tx_data   <= HID_USAGE_NONE;
                            gap_count <= '0;
                            state     <= ST_GAP;
                        end else begin
                            byte_idx <= next_idx;
                            tx_data  <= next_byte;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_count == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_count <= gap_count + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
